passwd_gen: RTL and testbench

Candidate-password generator feeding the password checker core. It enumerates every NCHARS-symbol password over a symbol alphabet of CHARSET_MAX+1 codes, odometer-style. Each candidate is presented on a valid/ready handshake. Generation halts on checker FOUND (via STOP), on exhaustion, or on abort; the 40-bit candidate bus matches the checker's PASSWD_OUT format.

---
 rtl/passwd_pkg.sv | 24 ++
 rtl/passwd_digit.sv | 58 +++++
 rtl/passwd_gen.sv | 176 +++++++++++++++++
 tb/tb_passwd_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/passwd_pkg.sv
// -----------------------------------------------------------------------------
// passwd_pkg
// Shared definitions for the candidate-password generator:
//   - state_e          : generator FSM states (IDLE / RUN / FIN)
//   - DEF_*            : default geometry (8 symbols x 5 bits, codes 0..31)
//   - passwd_w()       : candidate bus width for a given geometry
// -----------------------------------------------------------------------------
package passwd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam int DEF_NCHARS      = 8;
    localparam int DEF_CHAR_W      = 5;
    localparam int DEF_CHARSET_MAX = 31;

    function automatic int passwd_w(input int nchars, input int char_w);
        return nchars * char_w;
    endfunction

endpackage

// File: rtl/passwd_digit.sv
// -----------------------------------------------------------------------------
// passwd_digit
// One odometer symbol register. Counts 0..CHARSET_MAX and wraps, raising
// carry_out while it is being incremented from CHARSET_MAX. A load has
// priority over an increment.
//
// Ports:
//   CLK, RST_N  clock / async active-low reset
//   load        capture load_val this edge
//   load_val    value captured on load
//   inc         carry-in: advance this symbol
//   sym         current symbol code
//   carry_out   inc & (sym == CHARSET_MAX)
// -----------------------------------------------------------------------------
module passwd_digit
    import passwd_pkg::*;
#(
    parameter int CHAR_W      = DEF_CHAR_W,
    parameter int CHARSET_MAX = DEF_CHARSET_MAX
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic [CHAR_W-1:0] load_val,
    input  logic              inc,
    output logic [CHAR_W-1:0] sym,
    output logic              carry_out
);

    localparam logic [CHAR_W-1:0] MAX_SYM = CHAR_W'(CHARSET_MAX);

    logic [CHAR_W-1:0] sym_q;
    logic [CHAR_W-1:0] sym_d;
    logic              at_max;

    assign at_max = (sym_q == MAX_SYM);

    always_comb begin
        sym_d = sym_q;
        if (load) begin
            sym_d = load_val;
        end else if (inc) begin
            sym_d = at_max ? '0 : sym_q + CHAR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sym_q <= '0;
        end else begin
            sym_q <= sym_d;
        end
    end

    assign sym       = sym_q;
    assign carry_out = inc & at_max;

endmodule

// File: rtl/passwd_gen.sv
// -----------------------------------------------------------------------------
// passwd_gen
// Enumerates every NCHARS-symbol candidate over codes 0..CHARSET_MAX,
// odometer-style, and presents each one on a VALID/READY handshake.
// Stops on STOP (checker FOUND), on exhaustion, or on abort.
//
// Optional build macro: PASSWD_GEN_SEED_EN adds the SEED input; START then
// loads SEED (each symbol clamped to CHARSET_MAX) instead of all-zero.
//
// Ports:
//   CLK, RST_N   clock / async active-low reset
//   START        one-cycle pulse, begin enumeration (ignored while running)
//   STOP         abort / freeze, dominates START
//   READY        downstream accepts the candidate this cycle
//   SEED         (PASSWD_GEN_SEED_EN only) starting candidate
//   VALID        PASSWD_OUT holds a candidate
//   PASSWD_OUT   candidate, symbol 0 in bits [0:CHAR_W-1]
//   BUSY         high while enumerating
//   DONE         sticky: last candidate accepted
//   COUNT        candidates accepted since START, saturating
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | not enumerating; PASSWD_OUT/COUNT frozen for readback
// RUN   | presenting candidates, advancing on each transfer
// FIN   | keyspace exhausted; last candidate held, DONE set
// -----------------------------------------------------------------------------
module passwd_gen
    import passwd_pkg::*;
#(
    parameter int NCHARS      = DEF_NCHARS,
    parameter int CHAR_W      = DEF_CHAR_W,
    parameter int CHARSET_MAX = DEF_CHARSET_MAX
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       START,
    input  logic                       STOP,
    input  logic                       READY,
`ifdef PASSWD_GEN_SEED_EN
    input  logic [0:NCHARS*CHAR_W-1]   SEED,
`endif
    output logic                       VALID,
    output logic [0:NCHARS*CHAR_W-1]   PASSWD_OUT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [0:NCHARS*CHAR_W-1]   COUNT
);

    localparam int W = passwd_w(NCHARS, CHAR_W);

    state_e         state_q, state_d;
    logic           done_q, done_d;
    logic [0:W-1]   count_q, count_d;

    logic           xfer;
    logic           last_xfer;
    logic           load_start;
    logic           load_any;
    logic [0:W-1]   start_val;
    logic [0:W-1]   load_val_all;

    assign xfer = (state_q == ST_RUN) && READY;

    // ------------------------------------------------------------------
    // Start value: zero, or the clamped seed when seeding is built in.
    // ------------------------------------------------------------------
`ifdef PASSWD_GEN_SEED_EN
    localparam logic [CHAR_W-1:0] MAX_SYM = CHAR_W'(CHARSET_MAX);

    always_comb begin
        logic [CHAR_W-1:0] seed_sym;
        start_val = '0;
        seed_sym  = '0;
        for (int i = 0; i < NCHARS; i++) begin
            seed_sym = SEED[i*CHAR_W +: CHAR_W];
            start_val[i*CHAR_W +: CHAR_W] = (seed_sym > MAX_SYM) ? MAX_SYM : seed_sym;
        end
    end
`else
    assign start_val = '0;
`endif

    // The final transfer would wrap the odometer to zero; instead every
    // digit reloads its own value so the last candidate stays parked.
    assign load_any     = load_start | last_xfer;
    assign load_val_all = load_start ? start_val : PASSWD_OUT;

    // ------------------------------------------------------------------
    // Odometer: carry enters at the rightmost symbol and ripples left.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCHARS; i++) begin : g_sym
        logic inc_i;
        logic carry_o;

        if (i == NCHARS - 1) begin : g_lsb
            assign inc_i = xfer;
        end else begin : g_mid
            assign inc_i = g_sym[i+1].carry_o;
        end

        passwd_digit #(
            .CHAR_W      (CHAR_W),
            .CHARSET_MAX (CHARSET_MAX)
        ) u_digit (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .load      (load_any),
            .load_val  (load_val_all[i*CHAR_W +: CHAR_W]),
            .inc       (inc_i),
            .sym       (PASSWD_OUT[i*CHAR_W +: CHAR_W]),
            .carry_out (carry_o)
        );
    end

    // A carry out of the leftmost symbol means the all-max candidate moved.
    assign last_xfer = g_sym[0].carry_o;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        count_d    = count_q;
        load_start = 1'b0;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (START && !STOP) begin
                    state_d    = ST_RUN;
                    load_start = 1'b1;
                    count_d    = '0;
                    done_d     = 1'b0;
                end else if (STOP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    count_d = (&count_q) ? count_q : count_q + W'(1);
                end
                if (last_xfer) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end
                // Abort wins over exhaustion, but a coincident transfer
                // has already been counted and advanced above.
                if (STOP) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign VALID = (state_q == ST_RUN);
    assign BUSY  = (state_q == ST_RUN);
    assign DONE  = done_q;
    assign COUNT = count_q;

endmodule

// File: tb/tb_passwd_gen.sv
// -----------------------------------------------------------------------------
// tb_passwd_gen
// Two generators: "a" with default geometry (8 x 5 bit) and "b" with a tiny
// 2-symbol, codes 0..2 keyspace for exhaustion. Expected candidates are
// queued by the stimulus; per-instance monitors pop and compare on each
// VALID & READY handshake.
// -----------------------------------------------------------------------------
module tb_passwd_gen;

    logic        clk;
    logic        rst_n;

    logic        start_a, stop_a, ready_a;
    logic        valid_a, busy_a, done_a;
    logic [0:39] out_a, count_a, seed_a;

    logic        start_b, stop_b, ready_b;
    logic        valid_b, busy_b, done_b;
    logic [0:3]  out_b, count_b, seed_b;

    int vectors;
    int miscompares;

    logic [39:0] q_a[$];
    logic [3:0]  q_b[$];

    passwd_gen dut_a (
        .CLK        (clk),
        .RST_N      (rst_n),
        .START      (start_a),
        .STOP       (stop_a),
        .READY      (ready_a),
`ifdef PASSWD_GEN_SEED_EN
        .SEED       (seed_a),
`endif
        .VALID      (valid_a),
        .PASSWD_OUT (out_a),
        .BUSY       (busy_a),
        .DONE       (done_a),
        .COUNT      (count_a)
    );

    passwd_gen #(
        .NCHARS      (2),
        .CHAR_W      (2),
        .CHARSET_MAX (2)
    ) dut_b (
        .CLK        (clk),
        .RST_N      (rst_n),
        .START      (start_b),
        .STOP       (stop_b),
        .READY      (ready_b),
`ifdef PASSWD_GEN_SEED_EN
        .SEED       (seed_b),
`endif
        .VALID      (valid_b),
        .PASSWD_OUT (out_b),
        .BUSY       (busy_b),
        .DONE       (done_b),
        .COUNT      (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: sample mid-cycle, a handshake seen here completes next edge.
    always @(negedge clk) begin
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL xfer_a: got %0h expected no transfer", out_a);
            end else begin
                chk("xfer_a", out_a, q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b === 1'b1 && ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL xfer_b: got %0h expected no transfer", out_b);
            end else begin
                chk("xfer_b", out_b, q_b.pop_front());
            end
        end
    end

    initial begin
        logic [3:0] exh_seq [9];
        logic       got_done;

        exh_seq = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};

        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; ready_a = 1'b0; seed_a = '0;
        start_b = 1'b0; stop_b = 1'b0; ready_b = 1'b0; seed_b = '0;

        // ---------------- reset values
        #12;
        chk("rst_valid_a", valid_a, 0);
        chk("rst_busy_a",  busy_a,  0);
        chk("rst_done_a",  done_a,  0);
        chk("rst_out_a",   out_a,   0);
        chk("rst_count_a", count_a, 0);
        chk("rst_valid_b", valid_b, 0);
        rst_n = 1'b1;
        tick;

        // ---------------- backpressure: READY 1,0,0,1
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("lat_valid_a", valid_a, 1);
        chk("lat_busy_a",  busy_a,  1);
        chk("lat_out_a",   out_a,   0);
        q_a.push_back(40'd0);
        q_a.push_back(40'd1);
        ready_a = 1'b1;
        tick;
        ready_a = 1'b0;
        chk("bp_out1", out_a, 1);
        tick;
        chk("bp_stall_out",   out_a,   1);
        chk("bp_stall_count", count_a, 1);
        tick;
        ready_a = 1'b1;
        chk("bp_stall_out2", out_a, 1);
        tick;
        ready_a = 1'b0;
        chk("bp_out2",   out_a,   2);
        chk("bp_count2", count_a, 2);

        // ---------------- STOP freezes position
        stop_a = 1'b1;
        tick;
        stop_a = 1'b0;
        chk("stop_valid", valid_a, 0);
        chk("stop_busy",  busy_a,  0);
        chk("stop_out",   out_a,   2);
        chk("stop_count", count_a, 2);

        // ---------------- 5 transfers then STOP
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("restart_out",   out_a,   0);
        chk("restart_count", count_a, 0);
        for (int i = 0; i < 5; i++) q_a.push_back(40'(i));
        ready_a = 1'b1;
        repeat (5) tick;
        ready_a = 1'b0;
        stop_a  = 1'b1;
        tick;
        stop_a = 1'b0;
        chk("stop5_valid", valid_a, 0);
        chk("stop5_out",   out_a,   5);
        chk("stop5_count", count_a, 5);

        // START with STOP: STOP wins
        start_a = 1'b1;
        stop_a  = 1'b1;
        tick;
        start_a = 1'b0;
        stop_a  = 1'b0;
        chk("ss_valid", valid_a, 0);
        chk("ss_out",   out_a,   5);
        tick;
        chk("ss_valid2", valid_a, 0);

        // ---------------- reset mid-run (asynchronous)
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int i = 0; i < 10; i++) q_a.push_back(40'(i));
        ready_a = 1'b1;
        repeat (10) tick;
        ready_a = 1'b0;
        chk("mid_count", count_a, 10);
        chk("mid_out",   out_a,   10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid_a, 0);
        chk("arst_out",   out_a,   0);
        chk("arst_count", count_a, 0);
        rst_n = 1'b1;
        tick;

`ifdef PASSWD_GEN_SEED_EN
        // ---------------- carry ripple from seed
        seed_a  = {5'd0, {7{5'd31}}};
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("seed_load", out_a, {5'd0, {7{5'd31}}});
        q_a.push_back({5'd0, {7{5'd31}}});
        ready_a = 1'b1;
        tick;
        ready_a = 1'b0;
        chk("seed_carry", out_a, {5'd1, 35'd0});
        chk("seed_count", count_a, 1);
        stop_a = 1'b1;
        tick;
        stop_a = 1'b0;
`endif

        // ---------------- exhaustion on the small instance
        for (int i = 0; i < 9; i++) q_b.push_back(exh_seq[i]);
        ready_b = 1'b1;
        start_b = 1'b1;
        tick;
        start_b  = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            tick;
            if (done_b === 1'b1) got_done = 1'b1;
        end
        chk("exh_done_seen", got_done, 1);
        chk("exh_valid", valid_b, 0);
        chk("exh_busy",  busy_b,  0);
        chk("exh_count", count_b, 9);
        chk("exh_out",   out_b,   4'hA);
        tick;
        chk("exh_hold_out", out_b, 4'hA);

        // ---------------- restart from FIN
        ready_b = 1'b0;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("fin_restart_done",  done_b,  0);
        chk("fin_restart_out",   out_b,   0);
        chk("fin_restart_valid", valid_b, 1);
        chk("fin_restart_count", count_b, 0);

        // run out again, then STOP in FIN keeps DONE
        for (int i = 0; i < 9; i++) q_b.push_back(exh_seq[i]);
        ready_b = 1'b1;
        repeat (9) tick;
        ready_b = 1'b0;
        chk("exh2_done", done_b, 1);
        stop_b = 1'b1;
        tick;
        stop_b = 1'b0;
        chk("finstop_done",  done_b,  1);
        chk("finstop_valid", valid_b, 0);
        chk("finstop_busy",  busy_b,  0);

`ifdef PASSWD_GEN_SEED_EN
        // seed symbol above CHARSET_MAX clamps: {1,3} -> {1,2}
        seed_b  = 4'b0111;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("seed_clamp", out_b, 4'b0110);
        stop_b = 1'b1;
        tick;
        stop_b = 1'b0;
`endif

        repeat (2) tick;
        chk("q_a_drained", 64'(q_a.size()), 0);
        chk("q_b_drained", 64'(q_b.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
